channel_sample_buffer: RTL and testbench

Per-channel capture RAM and readout engine sitting directly downstream of the trigger block's write-enable output.
- Capture: while `we` is high, stores every ADC sample of one channel into a circular buffer.
- Readout: on a host request, streams the most recent N samples, oldest first, to the Tx protocol over a rdy/ack/eof byte handshake.
- Instantiated once per channel (ch1, ch2).

---
 rtl/channel_sample_buffer_pkg.sv | 16 +
 rtl/channel_sample_buffer_sample_ram.sv | 27 ++
 rtl/channel_sample_buffer.sv | 148 ++++++++++++++
 tb/tb_channel_sample_buffer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_sample_buffer_pkg.sv
// Shared definitions for the per-channel capture buffer: readout FSM encoding
// and the fixed widths of the Tx byte and the sample counters.
package channel_sample_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

  localparam int DEFAULT_RAM_ADDR_WIDTH = 12;
  localparam int TX_WIDTH               = 8;
  localparam int COUNT_WIDTH            = 16;

endpackage

// File: rtl/channel_sample_buffer_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module channel_sample_buffer_sample_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/channel_sample_buffer.sv
// Per-channel circular capture buffer with a readout engine that streams the
// most recent N samples, oldest first, over a rdy/ack/eof byte handshake.
module channel_sample_buffer
  import channel_sample_buffer_pkg::*;
#(
  parameter int BITS_ADC       = 8,
  parameter int RAM_ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   we,
  input  logic [BITS_ADC-1:0]    adc_data,
  input  logic                   adc_rdy,
  input  logic [COUNT_WIDTH-1:0] num_samples,
  input  logic                   rqst_data,
  output logic [TX_WIDTH-1:0]    tx_data,
  output logic                   tx_rdy,
  output logic                   tx_eof,
  input  logic                   tx_ack,
  output logic                   busy
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int FW = RAM_ADDR_WIDTH + 1;
  localparam logic [FW-1:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [TX_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                   tx_rdy_q, tx_rdy_d;
  logic                   tx_eof_q, tx_eof_d;
  logic                   busy_q, busy_d;

  logic                   wr_en;
  logic [AW-1:0]          wr_ptr_post;
  logic [FW-1:0]          fill_post;
  logic [COUNT_WIDTH-1:0] len;
  logic [BITS_ADC-1:0]    ram_q;

  channel_sample_buffer_sample_ram #(
    .DATA_W (BITS_ADC),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (adc_data),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_q)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    tx_data_d   = tx_data_q;
    tx_rdy_d    = tx_rdy_q;
    tx_eof_d    = tx_eof_q;
    wr_en       = 1'b0;
    wr_ptr_post = wr_ptr_q;
    fill_post   = fill_q;
    len         = '0;

    unique case (state_q)
      IDLE: begin
        if (clear) begin
          wr_ptr_d = '0;
          fill_d   = '0;
        end else begin
          if (we && adc_rdy) begin
            wr_en       = 1'b1;
            wr_ptr_post = wr_ptr_q + 1'b1;
            if (fill_q != DEPTH) begin
              fill_post = fill_q + 1'b1;
            end
          end
          wr_ptr_d = wr_ptr_post;
          fill_d   = fill_post;
          // A write in the accept cycle is counted before sizing the burst.
          len = (num_samples < COUNT_WIDTH'(fill_post)) ? num_samples
                                                        : COUNT_WIDTH'(fill_post);
          if (rqst_data && (len != '0)) begin
            rd_ptr_d    = wr_ptr_post - len[AW-1:0];
            remaining_d = len;
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        tx_data_d = TX_WIDTH'(ram_q);
        tx_rdy_d  = 1'b1;
        tx_eof_d  = (remaining_q == COUNT_WIDTH'(1));
        state_d   = SEND;
      end
      SEND: begin
        if (tx_ack) begin
          tx_rdy_d    = 1'b0;
          tx_eof_d    = 1'b0;
          remaining_d = remaining_q - 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          state_d     = (remaining_q == COUNT_WIDTH'(1)) ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      remaining_q <= '0;
      tx_data_q   <= '0;
      tx_rdy_q    <= 1'b0;
      tx_eof_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      tx_data_q   <= tx_data_d;
      tx_rdy_q    <= tx_rdy_d;
      tx_eof_q    <= tx_eof_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_rdy  = tx_rdy_q;
  assign tx_eof  = tx_eof_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_channel_sample_buffer.sv
// Scoreboard bench for channel_sample_buffer with a 16-deep buffer: directed
// bursts push expected bytes, a negedge monitor pops and compares.
module tb_channel_sample_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        we;
  logic [7:0]  adc_data;
  logic        adc_rdy;
  logic [15:0] num_samples;
  logic        rqst_data;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic        tx_eof;
  logic        tx_ack;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int ack_delay = 0;

  logic [8:0] exp_q[$];   // {eof, data}

  always #5 clk = ~clk;

  channel_sample_buffer #(
    .BITS_ADC       (8),
    .RAM_ADDR_WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .we          (we),
    .adc_data    (adc_data),
    .adc_rdy     (adc_rdy),
    .num_samples (num_samples),
    .rqst_data   (rqst_data),
    .tx_data     (tx_data),
    .tx_rdy      (tx_rdy),
    .tx_eof      (tx_eof),
    .tx_ack      (tx_ack),
    .busy        (busy)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input int v);
    we = 1'b1;
    adc_rdy = 1'b1;
    adc_data = 8'(v);
    step();
    we = 1'b0;
    adc_rdy = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic request(input int n);
    num_samples = 16'(n);
    rqst_data = 1'b1;
    step();
    rqst_data = 1'b0;
  endtask

  task automatic push_range(input int first, input int last);
    for (int v = first; v <= last; v++) begin
      exp_q.push_back({(v == last), 8'(v)});
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout_busy", int'(busy), 0);
  endtask

  // Acknowledge each presented byte after ack_delay cycles.
  initial begin : acker
    int cnt = 0;
    tx_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_ack) begin
        tx_ack = 1'b0;
        cnt = 0;
      end else if (tx_rdy) begin
        if (cnt >= ack_delay) begin
          tx_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // New byte = tx_rdy seen high after being low; while held it must not move.
  initial begin : monitor
    bit         byte_open = 1'b0;
    logic [7:0] held_data = '0;
    logic       held_eof  = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (tx_rdy) begin
        if (!byte_open) begin
          $display("byte data=%0d eof=%0d", tx_data, tx_eof);
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", int'(tx_data), -1);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", int'(tx_data), int'(e[7:0]));
            chk("tx_eof", int'(tx_eof), int'(e[8]));
          end
          byte_open = 1'b1;
          held_data = tx_data;
          held_eof  = tx_eof;
        end else begin
          chk("stall_data", int'(tx_data), int'(held_data));
          chk("stall_eof", int'(tx_eof), int'(held_eof));
        end
      end else begin
        byte_open = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit saw_rdy;
    bit saw_busy;
    int n;
    rst = 1'b1;
    clear = 1'b0;
    we = 1'b0;
    adc_data = '0;
    adc_rdy = 1'b0;
    num_samples = '0;
    rqst_data = 1'b0;
    repeat (3) step();
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_rdy", int'(tx_rdy), 0);
    chk("rst_tx_eof", int'(tx_eof), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Basic readout with first-byte latency.
    pulse_clear();
    for (int v = 1; v <= 10; v++) write_sample(v);
    push_range(7, 10);
    request(4);
    chk("busy_after_accept", int'(busy), 1);
    chk("rdy_lat_1", int'(tx_rdy), 0);
    step();
    chk("rdy_lat_2", int'(tx_rdy), 0);
    step();
    chk("rdy_lat_3", int'(tx_rdy), 1);
    wait_idle(200);
    chk("basic_left", exp_q.size(), 0);

    // Wrap-around and fill saturation.
    pulse_clear();
    for (int v = 0; v < 20; v++) write_sample(v);
    push_range(4, 19);
    request(16);
    wait_idle(400);
    chk("wrap_left", exp_q.size(), 0);
    push_range(4, 19);
    request(100);
    wait_idle(400);
    chk("sat_left", exp_q.size(), 0);

    // Clip to fill, then empty request.
    pulse_clear();
    for (int v = 5; v <= 7; v++) write_sample(v);
    push_range(5, 7);
    request(100);
    wait_idle(200);
    chk("clip_left", exp_q.size(), 0);
    pulse_clear();
    request(1);
    saw_rdy = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_rdy) saw_rdy = 1'b1;
      if (busy) saw_busy = 1'b1;
      step();
    end
    chk("empty_rdy", int'(saw_rdy), 0);
    chk("empty_busy", int'(saw_busy), 0);

    // Handshake stall.
    ack_delay = 5;
    pulse_clear();
    for (int v = 20; v <= 29; v++) write_sample(v);
    push_range(25, 29);
    request(5);
    wait_idle(500);
    chk("stall_left", exp_q.size(), 0);
    ack_delay = 0;

    // Writes blocked during readout.
    pulse_clear();
    for (int v = 40; v <= 47; v++) write_sample(v);
    push_range(44, 47);
    request(4);
    n = 0;
    while (busy && n < 200) begin
      we = 1'b1;
      adc_rdy = ~adc_rdy;
      adc_data = 8'hAA;
      step();
      n++;
    end
    we = 1'b0;
    adc_rdy = 1'b0;
    chk("block_busy", int'(busy), 0);
    chk("block_left", exp_q.size(), 0);
    push_range(40, 47);
    request(100);
    wait_idle(300);
    chk("block_after_left", exp_q.size(), 0);

    // Write in the accept cycle is included in the burst.
    push_range(46, 48);
    we = 1'b1;
    adc_rdy = 1'b1;
    adc_data = 8'd48;
    request(3);
    we = 1'b0;
    adc_rdy = 1'b0;
    wait_idle(200);
    chk("accept_write_left", exp_q.size(), 0);

    // Reset while byte 3 of 4 is held.
    ack_delay = 3;
    pulse_clear();
    for (int v = 60; v <= 63; v++) write_sample(v);
    exp_q.push_back({1'b0, 8'd60});
    exp_q.push_back({1'b0, 8'd61});
    exp_q.push_back({1'b0, 8'd62});
    request(4);
    n = 0;
    while (!(tx_rdy && tx_data == 8'd62) && n < 100) begin
      step();
      n++;
    end
    chk("reach_byte3", int'(tx_rdy && tx_data == 8'd62), 1);
    rst = 1'b1;
    step();
    chk("midrst_tx_rdy", int'(tx_rdy), 0);
    chk("midrst_tx_eof", int'(tx_eof), 0);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    chk("midrst_left", exp_q.size(), 0);
    request(4);
    saw_rdy = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx_rdy) saw_rdy = 1'b1;
      if (busy) saw_busy = 1'b1;
      step();
    end
    chk("postrst_rdy", int'(saw_rdy), 0);
    chk("postrst_busy", int'(saw_busy), 0);
    ack_delay = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
